// File: rtl/basic_cpu_core.sv
// Accumulator-machine core: switch-loaded internal memory, T0..T6 sequencer and a
// memory-reference instruction set with indirect addressing, carry flag E, ISZ and halt.
module basic_cpu_core #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 12,
    parameter int MEM_DEPTH = 32,
    parameter int DATA_BASE = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              ld_prog,
    input  logic              ld_data,
    input  logic              restart,
    input  logic [DATA_W-1:0] din,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data,
    output logic [DATA_W-1:0] ac,
    output logic              e,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        sc,
    output logic              halted,
    output logic              busy
);

    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(MEM_DEPTH - 1);
    localparam logic [IDX_W-1:0] PTR_BASE = IDX_W'(DATA_BASE);

    typedef enum logic [2:0] {T0, T1, T2, T3, T4, T5, T6} sc_e;
    typedef enum logic [2:0] {
        OP_AND = 3'b000, OP_ADD = 3'b001, OP_LDA = 3'b010, OP_STA = 3'b011,
        OP_BUN = 3'b100, OP_SUB = 3'b101, OP_ISZ = 3'b110, OP_HLT = 3'b111
    } op_e;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    sc_e               sc_q, sc_d;
    logic [ADDR_W-1:0] pc_q, pc_d, ar_q, ar_d;
    logic [DATA_W-1:0] ir_q, ir_d, dr_q, dr_d, ac_q, ac_d;
    logic              e_q, e_d, i_q, i_d, halted_q, halted_d;
    logic [IDX_W-1:0]  pptr_q, pptr_d, dptr_q, dptr_d;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_ar;
    op_e               op;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return 32'(a) < 32'(MEM_DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] ptr_inc(input logic [IDX_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + IDX_W'(1);
    endfunction

    assign mem_ar   = in_range(ar_q) ? mem[ar_q[IDX_W-1:0]] : '0;
    assign dbg_data = in_range(dbg_addr) ? mem[dbg_addr[IDX_W-1:0]] : '0;
    assign op       = op_e'(ir_q[DATA_W-2:DATA_W-4]);

    // Loads and restart take the single write port and freeze the sequencer.
    always_comb begin
        sc_d      = sc_q;
        pc_d      = pc_q;
        ar_d      = ar_q;
        ir_d      = ir_q;
        dr_d      = dr_q;
        ac_d      = ac_q;
        e_d       = e_q;
        i_d       = i_q;
        halted_d  = halted_q;
        pptr_d    = pptr_q;
        dptr_d    = dptr_q;
        mem_we    = 1'b0;
        mem_waddr = '0;
        mem_wdata = '0;
        if (restart) begin
            pc_d     = '0;
            sc_d     = T0;
            halted_d = 1'b0;
        end else if (ld_prog) begin
            mem_we    = 1'b1;
            mem_waddr = ADDR_W'(pptr_q);
            mem_wdata = din;
            pptr_d    = ptr_inc(pptr_q);
        end else if (ld_data) begin
            mem_we    = 1'b1;
            mem_waddr = ADDR_W'(dptr_q);
            mem_wdata = din;
            dptr_d    = ptr_inc(dptr_q);
        end else if (run && !halted_q) begin
            case (sc_q)
                T0: begin
                    ar_d = pc_q;
                    sc_d = T1;
                end
                T1: begin
                    ir_d = mem_ar;
                    pc_d = pc_q + ADDR_W'(1);
                    sc_d = T2;
                end
                T2: begin
                    ar_d = ir_q[ADDR_W-1:0];
                    i_d  = ir_q[DATA_W-1];
                    sc_d = T3;
                end
                T3: begin
                    sc_d = T4;
                    if (op == OP_HLT) begin
                        halted_d = 1'b1;
                        sc_d     = T0;
                    end else if (i_q) begin
                        ar_d = mem_ar[ADDR_W-1:0];
                    end
                end
                T4: begin
                    sc_d = T5;
                    case (op)
                        OP_STA: begin
                            mem_we    = 1'b1;
                            mem_waddr = ar_q;
                            mem_wdata = ac_q;
                            sc_d      = T0;
                        end
                        OP_BUN: begin
                            pc_d = ar_q;
                            sc_d = T0;
                        end
                        OP_HLT:  sc_d = T0;
                        default: dr_d = mem_ar;
                    endcase
                end
                T5: begin
                    sc_d = T0;
                    case (op)
                        OP_AND: ac_d = ac_q & dr_q;
                        OP_ADD: {e_d, ac_d} = {1'b0, ac_q} + {1'b0, dr_q};
                        OP_LDA: ac_d = dr_q;
                        OP_SUB: begin
                            ac_d = ac_q - dr_q;
                            e_d  = (ac_q >= dr_q);
                        end
                        OP_ISZ: begin
                            dr_d = dr_q + DATA_W'(1);
                            sc_d = T6;
                        end
                        default: ;
                    endcase
                end
                T6: begin
                    mem_we    = 1'b1;
                    mem_waddr = ar_q;
                    mem_wdata = dr_q;
                    if (dr_q == '0) pc_d = pc_q + ADDR_W'(1);
                    sc_d      = T0;
                end
                default: sc_d = T0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sc_q     <= T0;
            pc_q     <= '0;
            ar_q     <= '0;
            ir_q     <= '0;
            dr_q     <= '0;
            ac_q     <= '0;
            e_q      <= 1'b0;
            i_q      <= 1'b0;
            halted_q <= 1'b0;
            pptr_q   <= '0;
            dptr_q   <= PTR_BASE;
        end else begin
            sc_q     <= sc_d;
            pc_q     <= pc_d;
            ar_q     <= ar_d;
            ir_q     <= ir_d;
            dr_q     <= dr_d;
            ac_q     <= ac_d;
            e_q      <= e_d;
            i_q      <= i_d;
            halted_q <= halted_d;
            pptr_q   <= pptr_d;
            dptr_q   <= dptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we && in_range(mem_waddr)) mem[mem_waddr[IDX_W-1:0]] <= mem_wdata;
    end

    assign ac     = ac_q;
    assign e      = e_q;
    assign pc     = pc_q;
    assign sc     = sc_q;
    assign halted = halted_q;
    assign busy   = run & ~halted_q & ~ld_prog & ~ld_data & ~restart;

endmodule

// File: tb/tb_basic_cpu_core.sv
// Bench for basic_cpu_core: instruction-level reference model compared every cycle,
// directed programs with hand-computed results, then randomized programs.
`timescale 1ns/1ps
module tb_basic_cpu_core;

    localparam int DW    = 16;
    localparam int AW    = 12;
    localparam int DEPTH = 32;
    localparam int BASE  = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          run = 1'b0, ld_prog = 1'b0, ld_data = 1'b0, restart = 1'b0;
    logic [DW-1:0] din = '0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_data, ac;
    logic          e, halted, busy;
    logic [AW-1:0] pc;
    logic [2:0]    sc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    basic_cpu_core #(
        .DATA_W(DW), .ADDR_W(AW), .MEM_DEPTH(DEPTH), .DATA_BASE(BASE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .ld_prog(ld_prog), .ld_data(ld_data),
        .restart(restart), .din(din), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .ac(ac), .e(e), .pc(pc), .sc(sc), .halted(halted), .busy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: whole instructions, effects applied on their final clock.
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_valid [DEPTH];
    int            m_pptr, m_dptr, m_step, m_len, m_op, m_ea;
    logic [DW-1:0] m_ac, m_dr;
    logic          m_e;
    logic [AW-1:0] m_pc;
    bit            m_halted;

    function automatic logic [DW-1:0] m_rd(input int a);
        return (a >= 0 && a < DEPTH) ? m_mem[a] : '0;
    endfunction

    task automatic m_wr(input int a, input logic [DW-1:0] v);
        if (a >= 0 && a < DEPTH) begin
            m_mem[a]   = v;
            m_valid[a] = 1'b1;
        end
    endtask

    task automatic model_step();
        logic [DW-1:0] w, p, v;
        int sum;
        if (!rst_n) begin
            m_pc = '0; m_ac = '0; m_e = 1'b0; m_halted = 1'b0;
            m_step = 0; m_pptr = 0; m_dptr = BASE;
        end else if (restart) begin
            m_pc = '0; m_step = 0; m_halted = 1'b0;
        end else if (ld_prog) begin
            m_wr(m_pptr, din);
            m_pptr = (m_pptr + 1) % DEPTH;
        end else if (ld_data) begin
            m_wr(m_dptr, din);
            m_dptr = (m_dptr + 1) % DEPTH;
        end else if (run && !m_halted) begin
            if (m_step == 0) begin
                w    = m_rd(int'(m_pc));
                m_op = int'(w[14:12]);
                if (w[15]) begin
                    p    = m_rd(int'(w[11:0]));
                    m_ea = int'(p[11:0]);
                end else begin
                    m_ea = int'(w[11:0]);
                end
                m_dr  = m_rd(m_ea);
                m_len = (m_op == 7) ? 4 : (m_op == 3 || m_op == 4) ? 5 : (m_op == 6) ? 7 : 6;
            end
            m_step++;
            if (m_step == 2) m_pc = m_pc + 1'b1;
            if (m_step == m_len) begin
                case (m_op)
                    0: m_ac = m_ac & m_dr;
                    1: begin
                        sum  = int'(m_ac) + int'(m_dr);
                        m_ac = DW'(sum);
                        m_e  = (sum > 65535);
                    end
                    2: m_ac = m_dr;
                    3: m_wr(m_ea, m_ac);
                    4: m_pc = AW'(m_ea);
                    5: begin
                        m_e  = (m_ac >= m_dr);
                        m_ac = DW'(int'(m_ac) - int'(m_dr) + 65536);
                    end
                    6: begin
                        v = m_dr + 1'b1;
                        m_wr(m_ea, v);
                        if (v == 0) m_pc = m_pc + 1'b1;
                    end
                    default: m_halted = 1'b1;
                endcase
                m_step = 0;
            end
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_valid[i] = 1'b0;
        end
        forever begin
            @(posedge clk or negedge rst_n);
            model_step();
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            check("sc", 32'(sc), 32'(m_step));
            check("pc", 32'(pc), 32'(m_pc));
            check("ac", 32'(ac), 32'(m_ac));
            check("e", 32'(e), 32'(m_e));
            check("halted", 32'(halted), 32'(m_halted));
            check("busy", 32'(busy), 32'(run && !m_halted && !ld_prog && !ld_data && !restart));
            if (int'(dbg_addr) >= DEPTH) check("dbg_oor", 32'(dbg_data), 32'd0);
            else if (m_valid[int'(dbg_addr)]) check("dbg_data", 32'(dbg_data), 32'(m_rd(int'(dbg_addr))));
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic lp(input logic [DW-1:0] w);
        ld_prog = 1'b1; din = w; cyc(); ld_prog = 1'b0;
    endtask

    task automatic ldd(input logic [DW-1:0] w);
        ld_data = 1'b1; din = w; cyc(); ld_data = 1'b0;
    endtask

    task automatic peek(input int a, output logic [DW-1:0] d);
        dbg_addr = AW'(a);
        #1;
        d = dbg_data;
    endtask

    task automatic run_to_halt(input int max, output int n);
        run = 1'b1;
        n = 0;
        while (halted !== 1'b1 && n < max) begin
            cyc();
            n++;
        end
        run = 1'b0;
        check("halt_reached", 32'(halted), 32'd1);
    endtask

    function automatic logic [DW-1:0] gen_word();
        logic [DW-1:0] w;
        w = DW'($urandom);
        if ($urandom_range(0, 3) != 0) w[11:0] = 12'($urandom_range(0, DEPTH + 4));
        if ($urandom_range(0, 3) != 0) w[15] = 1'b0;
        return w;
    endfunction

    function automatic logic [AW-1:0] gen_dbg();
        if ($urandom_range(0, 3) == 0) return AW'($urandom);
        return AW'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        int n, nd, steps;
        logic [DW-1:0] d;

        cyc();
        do_reset();
        check("rst_ac", 32'(ac), 32'd0);
        check("rst_sc", 32'(sc), 32'd0);

        // Load, add, store
        ldd(16'h0005); ldd(16'h0003);
        lp(16'h200A); lp(16'h100B); lp(16'h300C); lp(16'h7000);
        run_to_halt(100, n);
        check("t1_cycles", 32'(n), 32'd21);
        check("t1_ac", 32'(ac), 32'h0008);
        check("t1_e", 32'(e), 32'd0);
        check("t1_pc", 32'(pc), 32'd4);
        peek(12, d);
        check("t1_m12", 32'(d), 32'h0008);

        // Indirect load
        do_reset();
        lp(16'hA00A); lp(16'h7000);
        ldd(16'h000B); ldd(16'h1234);
        run_to_halt(100, n);
        check("t2_cycles", 32'(n), 32'd10);
        check("t2_ac", 32'(ac), 32'h1234);
        check("t2_pc", 32'(pc), 32'd2);

        // SUB with borrow, then without
        do_reset();
        lp(16'h2005); lp(16'h5007); lp(16'h7000); lp(16'h0000);
        lp(16'h0000); lp(16'h0005); lp(16'h0000); lp(16'h0007);
        run_to_halt(100, n);
        check("t3_ac_wrap", 32'(ac), 32'hFFFE);
        check("t3_e_borrow", 32'(e), 32'd0);
        do_reset();
        lp(16'h2005); lp(16'h5006); lp(16'h7000); lp(16'h0000);
        lp(16'h0000); lp(16'h0002); lp(16'h0001);
        run_to_halt(100, n);
        check("t3_ac", 32'(ac), 32'h0001);
        check("t3_e", 32'(e), 32'd1);

        // ISZ with and without skip
        do_reset();
        lp(16'h600A); lp(16'h7000); lp(16'h7000);
        ldd(16'hFFFF);
        run_to_halt(100, n);
        peek(10, d);
        check("t4_m10_zero", 32'(d), 32'h0000);
        check("t4_pc_skip", 32'(pc), 32'd3);
        check("t4_cycles", 32'(n), 32'd11);
        do_reset();
        ldd(16'h0004);
        run_to_halt(100, n);
        peek(10, d);
        check("t4_m10_inc", 32'(d), 32'h0005);
        check("t4_pc_noskip", 32'(pc), 32'd2);

        // Pause at T4, restart after halt, load priority
        do_reset();
        ldd(16'h0005); ldd(16'h0003);
        lp(16'h200A); lp(16'h100B); lp(16'h300C); lp(16'h7000);
        run = 1'b1;
        n = 0;
        while (sc !== 3'd4 && n < 50) begin
            cyc();
            n++;
        end
        run = 1'b0;
        check("t5_reach_sc4", 32'(sc), 32'd4);
        repeat (5) begin
            cyc();
            check("t5_hold_sc", 32'(sc), 32'd4);
        end
        run_to_halt(100, n);
        check("t5_resume_cycles", 32'(n), 32'd17);
        check("t5_ac", 32'(ac), 32'h0008);
        restart = 1'b1;
        cyc();
        restart = 1'b0;
        check("t5_rs_pc", 32'(pc), 32'd0);
        check("t5_rs_halted", 32'(halted), 32'd0);
        check("t5_rs_ac", 32'(ac), 32'h0008);
        ld_prog = 1'b1; ld_data = 1'b1; din = 16'hBEEF;
        cyc();
        ld_prog = 1'b0; ld_data = 1'b0;
        peek(4, d);
        check("t5_prio_prog", 32'(d), 32'hBEEF);
        peek(12, d);
        check("t5_prio_data", 32'(d), 32'h0008);
        ldd(16'h1111);
        peek(12, d);
        check("t5_dptr_held", 32'(d), 32'h1111);
        lp(16'h2222);
        peek(5, d);
        check("t5_pptr_inc", 32'(d), 32'h2222);

        // Reset in the middle of ADD
        do_reset();
        ldd(16'h0005); ldd(16'h0003);
        lp(16'h200A); lp(16'h100B); lp(16'h300C); lp(16'h7000);
        dbg_addr = '0;
        run = 1'b1;
        n = 0;
        while (!(pc === 12'd2 && sc === 3'd5) && n < 50) begin
            cyc();
            n++;
        end
        check("t6_reach", 32'(n), 32'd11);
        check("t6_ac_pre", 32'(ac), 32'h0005);
        #2 rst_n = 1'b0;
        #1;
        check("t6_ac", 32'(ac), 32'd0);
        check("t6_pc", 32'(pc), 32'd0);
        check("t6_sc", 32'(sc), 32'd0);
        check("t6_halted", 32'(halted), 32'd0);
        check("t6_mem", 32'(dbg_data), 32'h200A);
        cyc();
        run = 1'b0;
        rst_n = 1'b1;

        // Randomized programs against the model
        for (int it = 0; it < 10; it++) begin
            do_reset();
            for (int i = 0; i < DEPTH; i++) begin
                ld_prog  = 1'b1;
                ld_data  = ($urandom_range(0, 3) == 0);
                din      = gen_word();
                dbg_addr = gen_dbg();
                cyc();
            end
            ld_prog = 1'b0;
            ld_data = 1'b0;
            nd = $urandom_range(0, 30);
            for (int i = 0; i < nd; i++) begin
                ld_data  = 1'b1;
                din      = gen_word();
                dbg_addr = gen_dbg();
                cyc();
            end
            ld_data = 1'b0;
            steps = 0;
            while (halted !== 1'b1 && steps < 300) begin
                run      = ($urandom_range(0, 3) != 0);
                restart  = ($urandom_range(0, 99) == 0);
                dbg_addr = gen_dbg();
                cyc();
                restart = 1'b0;
                steps++;
            end
            run = 1'b0;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/basic_cpu_core.md
Name: basic_cpu_core

Overview:
- Parametrised, clocked successor to the accumulator-machine controller.
- Contains:
  - an internal memory, loaded word-by-word from the 7-segment input nibbles;
  - a built-in sequence counter T0..T6;
  - a full memory-reference instruction set, with indirect addressing, carry flag E, ISZ and halt.
- Sits between the switch/7-seg front end (din, load strobes, ac display) and the board clock.

Parameters:
- DATA_W, 16: word width of M, AC, DR, IR; must be at least ADDR_W+4.
- ADDR_W, 12: width of PC, AR and the IR address field.
- MEM_DEPTH, 32: number of memory words. Valid addresses are 0..MEM_DEPTH-1.
- DATA_BASE, 10: reset value of the data-load pointer.

Ports:
- clk  in  1  system clock; rising edge.
- rst_n  in  1  asynchronous active-low reset.
- run  in  1  execute enable. Low means the sequencer holds its state.
- ld_prog  in  1  write din to M[prog_ptr], then increment prog_ptr.
- ld_data  in  1  write din to M[data_ptr], then increment data_ptr.
- restart  in  1  synchronous pulse: PC<=0, SC<=T0, halted<=0.
- din  in  DATA_W  load word; the 7-seg nibbles concatenated, s3 as MSB.
- dbg_addr  in  ADDR_W  combinational memory read address.
- dbg_data  out  DATA_W  M[dbg_addr]; 0 if dbg_addr >= MEM_DEPTH.
- ac  out  DATA_W  accumulator.
- e  out  1  carry/no-borrow flag.
- pc  out  ADDR_W  program counter.
- sc  out  3  current timing state; 0..6 = T0..T6.
- halted  out  1  HLT executed.
- busy  out  1  high when run=1, halted=0, no load is active, and restart is low.

Behaviour:
- Reset values:
  - PC, AR, IR, DR, AC, E: 0.
  - I: 0. SC: T0. halted: 0.
  - prog_ptr: 0. data_ptr: DATA_BASE.
  - Memory contents are not reset.
- Instruction format:
  - I = IR[DATA_W-1].
  - op = IR[DATA_W-2:DATA_W-4].
  - addr = IR[ADDR_W-1:0].
- Priority per clock: restart > ld_prog > ld_data > execute.
  - Only one memory write occurs per clock.
  - Loads and restart freeze SC and all execution registers.
- Load pointers:
  - Each pointer increments once per cycle in which its strobe is high and wins priority.
  - Each pointer wraps to 0 after MEM_DEPTH-1.
- Memory accesses:
  - Writes to addresses >= MEM_DEPTH are dropped.
  - Reads from addresses >= MEM_DEPTH return 0.
- Execution advances only when run=1 and halted=0.
- Sequence, one state per clock:
  - T0: AR<=PC.
  - T1: IR<=M[AR]; PC<=PC+1, modulo 2^ADDR_W.
  - T2: AR<=addr; I<=IR MSB.
  - T3:
    - if op=111: halted<=1, SC<=T0;
    - else if I=1: AR<=M[AR][ADDR_W-1:0];
    - else AR unchanged.
  - T4:
    - 000/001/010/101/110: DR<=M[AR].
    - 011 STA: M[AR]<=AC, SC<=T0.
    - 100 BUN: PC<=AR, SC<=T0.
  - T5:
    - 000 AND: AC<=AC&DR.
    - 001 ADD: {E,AC}<=AC+DR.
    - 010 LDA: AC<=DR.
    - 101 SUB: AC<=AC-DR mod 2^DATA_W; E<=(AC>=DR) unsigned.
    - For these ops, SC<=T0.
    - 110 ISZ: DR<=DR+1.
  - T6 (ISZ only): M[AR]<=DR; if DR==0 then PC<=PC+1; SC<=T0.
- Cycle counts (run held high):
  - HLT: 4. STA, BUN: 5.
  - AND, ADD, LDA, SUB: 6. ISZ: 7.
  - Indirect addressing adds no cycles.
- Halt state: halted stays 1 until restart or rst_n. ac, e and pc stay stable.
- run dropped mid-instruction: SC and all registers hold; execution resumes in the same T state.
- rst_n asserted mid-instruction: all registers return to their reset values immediately. Memory is retained.

Test Plan:
- Load, add, store. Reset. ld_data: 0x0005 then 0x0003, giving M[10], M[11]. ld_prog: 0x200A, 0x100B, 0x300C, 0x7000. Then run=1.
  -> halted rises after 21 run cycles; ac=0x0008, e=0, pc=4, dbg_data@12=0x0008.
- Indirect load. M[0]=0xA00A, M[1]=0x7000, M[10]=0x000B, M[11]=0x1234. Run.
  -> ac=0x1234 after 10 cycles, halted.
- SUB wrap. Program: LDA 0x0005, then SUB 0x0007.
  -> ac=0xFFFE, e=0.
  Then SUB 0x0001 from ac=0x0002 -> ac=0x0001, e=1.
- ISZ skip. M[0]=0x600A, M[1]=0x7000, M[2]=0x7000, M[10]=0xFFFF.
  -> M[10]=0x0000; pc=3 at halt, because M[1] is skipped.
  Repeat with M[10]=0x0004 -> M[10]=0x0005, pc=2.
- Pause, load priority, restart.
  - Drop run at sc=4: sc holds 4 for 5 clocks, then finishes correctly.
  - ld_prog and ld_data both high: only M[prog_ptr] is written.
  - restart after halt: pc=0, halted=0, ac unchanged.
- Reset mid-op. Assert rst_n=0 at sc=5 of ADD.
  -> immediately ac=0, pc=0, sc=0, halted=0; dbg_data still shows the loaded program.
